// File: rtl/edic_ctrl_pkg.sv
// Control-word bit map, canned control words and FSM encodings for the microcode sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package edic_ctrl_pkg;

    localparam int DEF_STEP_W = 4;
    localparam int DEF_CTRL_W = 32;
    localparam int OPCODE_W   = 8;

    // Memory-stage control fields (most are active-low, hence the _N names)
    localparam int CTRL_PC_LOAD_N            = 0;
    localparam int CTRL_PC_N_EN              = 1;
    localparam int CTRL_PC_FROM_IMM          = 2;
    localparam int CTRL_MEM_PC_TO_RAM_N      = 3;
    localparam int CTRL_SP_UP                = 4;
    localparam int CTRL_SP_N_EN              = 5;
    localparam int CTRL_INSTR_N_WE           = 6;
    localparam int CTRL_INSTR_N_OE           = 7;
    localparam int CTRL_RAM_N_OE             = 8;
    localparam int CTRL_RAM_N_WE             = 9;
    localparam int CTRL_MAR0_N_WE            = 10;
    localparam int CTRL_MAR1_N_WE            = 11;
    localparam int CTRL_INSTR_IMM_TO_RAM_ADDR = 12;
    // Bits 13..29 belong to the ALU / register file
    localparam int CTRL_HALT                 = 30;
    localparam int CTRL_END                  = 31;

    // Everything deasserted: no PC move, no writes, no output enables
    localparam logic [31:0] CTRL_IDLE  = 32'h0000_0FEB;
    // Instruction fetch: latch instruction register and advance the PC
    localparam logic [31:0] CTRL_FETCH = 32'h0000_0FA9;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_HALTED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } seqState_t;

endpackage

// File: rtl/control_sequencer.sv
// Microcode sequencer: fetch, micro-step walk through an async ROM, halt/breakpoint/single-step control.
// Latency: one control word per non-halted cycle; a k-step instruction takes k+1 cycles including fetch.
// Backpressure: none; HALTED stalls the pipeline until an i_continue or i_step pulse.
module control_sequencer
    import edic_ctrl_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [OPCODE_W-1:0]        i_instrCode,
    output logic [OPCODE_W+STEP_W-1:0] o_uRomAddress,
    input  logic [CTRL_W-1:0]          i_uRomData,
    output logic [CTRL_W-1:0]          o_ctrlWord,
    output logic                       o_halt,
    input  logic                       i_breakpointHitN,
    input  logic                       i_continue,
    input  logic                       i_step,
    output logic [STEP_W-1:0]          o_step,
    output logic [1:0]                 o_state,
    output logic                       o_seqError
);

    localparam logic [STEP_W-1:0] STEP_ZERO  = '0;
    localparam logic [STEP_W-1:0] STEP_FIRST = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST  = '1;

    seqState_t         r_state;
    seqState_t         nextState;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] nextStep;
    logic              r_bpSkip;
    logic              nextBpSkip;
    logic              r_stepPending;
    logic              nextStepPending;
    logic              r_seqError;
    logic              nextSeqError;
    logic [CTRL_W-1:0] uWordMasked;
    logic              uEnd;
    logic              uHalt;
    logic              atLastStep;

    // Sequencing flags are consumed here, never forwarded to the datapath
    always_comb begin
        uWordMasked                = i_uRomData;
        uWordMasked[CTRL_W-1 -: 2] = 2'b00;
    end

    assign uEnd       = i_uRomData[CTRL_END];
    assign uHalt      = i_uRomData[CTRL_HALT];
    assign atLastStep = (r_step == STEP_LAST);

    // Next-state and control-word decode for fetch / execute / halted
    always_comb begin
        nextState       = r_state;
        nextStep        = r_step;
        nextBpSkip      = r_bpSkip;
        nextStepPending = r_stepPending;
        nextSeqError    = r_seqError;
        o_ctrlWord      = CTRL_IDLE;
        o_halt          = 1'b0;

        case (r_state)
            ST_FETCH: begin
                if (!i_breakpointHitN && !r_bpSkip) begin
                    // Stop before the fetch so the PC still points at the breakpoint
                    nextState = ST_HALTED;
                end else begin
                    o_ctrlWord = CTRL_FETCH;
                    nextState  = ST_EXEC;
                    nextStep   = STEP_FIRST;
                    nextBpSkip = 1'b0;
                end
            end

            ST_EXEC: begin
                o_ctrlWord = uWordMasked;
                if (uEnd || atLastStep) begin
                    nextStep = STEP_ZERO;
                    if (!uEnd) begin
                        nextSeqError = 1'b1;
                    end
                    if (uHalt || r_stepPending) begin
                        nextState       = ST_HALTED;
                        nextStepPending = 1'b0;
                    end else begin
                        nextState = ST_FETCH;
                    end
                end else begin
                    nextStep = r_step + STEP_W'(1);
                end
            end

            ST_HALTED: begin
                o_halt   = 1'b1;
                nextStep = STEP_ZERO;
                // Single-step has priority; both resume past a pending breakpoint
                if (i_step) begin
                    nextState       = ST_FETCH;
                    nextBpSkip      = 1'b1;
                    nextStepPending = 1'b1;
                end else if (i_continue) begin
                    nextState  = ST_FETCH;
                    nextBpSkip = 1'b1;
                end
            end

            default: begin
                nextState = ST_FETCH;
                nextStep  = STEP_ZERO;
            end
        endcase

        // Keep the datapath quiet and running while reset is held
        if (i_reset) begin
            o_ctrlWord = CTRL_IDLE;
            o_halt     = 1'b0;
        end
    end

    // State, micro-step counter and debug flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_FETCH;
            r_step        <= STEP_ZERO;
            r_bpSkip      <= 1'b0;
            r_stepPending <= 1'b0;
            r_seqError    <= 1'b0;
        end else begin
            r_state       <= nextState;
            r_step        <= nextStep;
            r_bpSkip      <= nextBpSkip;
            r_stepPending <= nextStepPending;
            r_seqError    <= nextSeqError;
        end
    end

    assign o_uRomAddress = {i_instrCode, r_step};
    assign o_step        = r_step;
    assign o_state       = r_state;
    assign o_seqError    = r_seqError;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written corner sequences, randomized programs.
// Latency: outputs checked on the falling edge of each cycle, inputs driven 1 ns after the rising edge.
// Backpressure: the bench plays the debugger, pulsing continue/step while the sequencer is halted.
module tb_control_sequencer;

    localparam logic [31:0] IDLE_W  = 32'h0000_0FEB;
    localparam logic [31:0] FETCH_W = 32'h0000_0FA9;

    logic        clk;
    logic        rst;
    logic [7:0]  instrCode;
    logic [11:0] uRomAddress;
    logic [31:0] uRomData;
    logic [31:0] ctrlWord;
    logic        halt;
    logic        bpN;
    logic        cont;
    logic        stp;
    logic [3:0]  stepDbg;
    logic [1:0]  stateDbg;
    logic        seqErr;

    logic [31:0] rom [4096];

    int tests = 0;
    int fails = 0;

    control_sequencer dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_instrCode     (instrCode),
        .o_uRomAddress   (uRomAddress),
        .i_uRomData      (uRomData),
        .o_ctrlWord      (ctrlWord),
        .o_halt          (halt),
        .i_breakpointHitN(bpN),
        .i_continue      (cont),
        .i_step          (stp),
        .o_step          (stepDbg),
        .o_state         (stateDbg),
        .o_seqError      (seqErr)
    );

    // Asynchronous microcode ROM
    assign uRomData = rom[uRomAddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bpN;
        logic        cont;
        logic        stp;
        logic [7:0]  op;
        logic [31:0] eCtrl;
        logic        eHalt;
        logic [11:0] eAddr;
        logic [1:0]  eState;
        logic [3:0]  eStep;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic c, input logic s, input logic [7:0] op);
        rst       = r;
        bpN       = b;
        cont      = c;
        stp       = s;
        instrCode = op;
    endtask

    // Check one cycle's outputs on the falling edge, then move past the next rising edge
    task automatic checkCycle(input string tag, input logic [31:0] eCtrl, input logic eHalt,
                              input logic [11:0] eAddr, input logic [1:0] eState,
                              input logic [3:0] eStep, input logic eSeq);
        @(negedge clk);
        chk(tag, "ctrl", ctrlWord, eCtrl);
        chk(tag, "halt", {31'd0, halt}, {31'd0, eHalt});
        chk(tag, "addr", {20'd0, uRomAddress}, {20'd0, eAddr});
        chk(tag, "state", {30'd0, stateDbg}, {30'd0, eState});
        chk(tag, "step", {28'd0, stepDbg}, {28'd0, eStep});
        chk(tag, "seqErr", {31'd0, seqErr}, {31'd0, eSeq});
        @(posedge clk);
        #1;
    endtask

    // Length of a microprogram: first step carrying END, or the last step if none does
    function automatic int progLen(input logic [7:0] op);
        logic [31:0] w;
        for (int s = 1; s <= 15; s++) begin
            w = rom[{op, 4'(s)}];
            if (w[31]) return s;
        end
        return 15;
    endfunction

    initial begin
        logic        mHalted;
        logic        mSkip;
        logic        mPending;
        logic        mSeq;
        logic [7:0]  op;
        logic [31:0] w;
        logic        b;
        logic        c;
        logic        s;
        int          k;

        for (int a = 0; a < 4096; a++) rom[a] = 32'h0;
        rom[12'h101] = 32'h0000_0EEB;
        rom[12'h102] = 32'h8000_0FEB;
        rom[12'h201] = 32'h0000_0123;
        rom[12'h202] = 32'hC000_0FEB;
        // Opcode 0x30 stays all-zero: a microprogram with no END anywhere
        for (int o = 0; o < 8; o++) begin
            logic noEnd;
            k     = $urandom_range(1, 15);
            noEnd = ($urandom_range(0, 7) == 0);
            if (noEnd) k = 15;
            for (int st = 0; st < 16; st++) begin
                w     = $urandom;
                w[31] = (st == k) && !noEnd;
                rom[{8'h40 + 8'(o), 4'(st)}] = w;
            end
        end

        //               bpN   cont  stp   op     ctrl          halt  addr     st    step
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0FA9, 1'b0, 12'h100, 2'd0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h10, 32'h0000_0EEB, 1'b0, 12'h101, 2'd1, 4'd1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h10, 32'h0000_0FEB, 1'b0, 12'h102, 2'd1, 4'd2};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FA9, 1'b0, 12'h200, 2'd0, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0123, 1'b0, 12'h201, 2'd1, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FEB, 1'b0, 12'h202, 2'd1, 4'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FEB, 1'b1, 12'h200, 2'd2, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FEB, 1'b1, 12'h200, 2'd2, 4'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h20, 32'h0000_0FEB, 1'b1, 12'h200, 2'd2, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FA9, 1'b0, 12'h200, 2'd0, 4'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0123, 1'b0, 12'h201, 2'd1, 4'd1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0000_0FEB, 1'b0, 12'h202, 2'd1, 4'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h10, 32'h0000_0FEB, 1'b1, 12'h100, 2'd2, 4'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0FA9, 1'b0, 12'h100, 2'd0, 4'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0EEB, 1'b0, 12'h101, 2'd1, 4'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0FEB, 1'b0, 12'h102, 2'd1, 4'd2};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0FEB, 1'b1, 12'h100, 2'd2, 4'd0};

        // Reset: idle word, not halted, counters cleared
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        @(posedge clk);
        #1;
        checkCycle("reset", IDLE_W, 1'b0, 12'h100, 2'd0, 4'd0, 1'b0);

        // Directed table: plain instruction, HALT|END, continue, step+continue together
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, vecs[i].bpN, vecs[i].cont, vecs[i].stp, vecs[i].op);
            checkCycle($sformatf("vec%0d", i), vecs[i].eCtrl, vecs[i].eHalt, vecs[i].eAddr,
                       vecs[i].eState, vecs[i].eStep, 1'b0);
        end

        // Breakpoint held low: continue skips it once, next fetch stops again
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
        checkCycle("bp_resume", IDLE_W, 1'b1, 12'h100, 2'd2, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
        checkCycle("bp_skipfetch", FETCH_W, 1'b0, 12'h100, 2'd0, 4'd0, 1'b0);
        checkCycle("bp_exec1", 32'h0000_0EEB, 1'b0, 12'h101, 2'd1, 4'd1, 1'b0);
        checkCycle("bp_exec2", 32'h0000_0FEB, 1'b0, 12'h102, 2'd1, 4'd2, 1'b0);
        checkCycle("bp_stop", IDLE_W, 1'b0, 12'h100, 2'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        checkCycle("bp_halted", IDLE_W, 1'b1, 12'h100, 2'd2, 4'd0, 1'b0);

        // Runaway microprogram: 15 steps, then sticky sequence error
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h30);
        checkCycle("run_resume", IDLE_W, 1'b1, 12'h300, 2'd2, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h30);
        checkCycle("run_fetch", FETCH_W, 1'b0, 12'h300, 2'd0, 4'd0, 1'b0);
        for (int n = 1; n <= 15; n++) begin
            checkCycle($sformatf("run_step%0d", n), 32'h0, 1'b0, {8'h30, 4'(n)}, 2'd1, 4'(n), 1'b0);
        end
        checkCycle("run_refetch", FETCH_W, 1'b0, 12'h300, 2'd0, 4'd0, 1'b1);
        checkCycle("run_sticky1", 32'h0, 1'b0, 12'h301, 2'd1, 4'd1, 1'b1);
        checkCycle("run_sticky2", 32'h0, 1'b0, 12'h302, 2'd1, 4'd2, 1'b1);

        // Reset in the middle of execute step 3
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
        checkCycle("rst_exec3", IDLE_W, 1'b0, 12'h303, 2'd1, 4'd3, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h30);
        checkCycle("rst_after", FETCH_W, 1'b0, 12'h300, 2'd0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
        checkCycle("rst_again", IDLE_W, 1'b0, 12'h301, 2'd1, 4'd1, 1'b0);

        // Randomized programs against an instruction-level model
        mHalted  = 1'b0;
        mSkip    = 1'b0;
        mPending = 1'b0;
        mSeq     = 1'b0;
        for (int it = 0; it < 300; it++) begin
            op = 8'h40 + 8'($urandom_range(0, 7));
            if (mHalted) begin
                s = ($urandom_range(0, 3) == 0);
                c = ($urandom_range(0, 3) == 0);
                b = 1'($urandom_range(0, 1));
                drive(1'b0, b, c, s, op);
                checkCycle("rnd_halted", IDLE_W, 1'b1, {op, 4'h0}, 2'd2, 4'd0, mSeq);
                if (s) begin
                    mHalted  = 1'b0;
                    mSkip    = 1'b1;
                    mPending = 1'b1;
                end else if (c) begin
                    mHalted = 1'b0;
                    mSkip   = 1'b1;
                end
            end else begin
                b = ($urandom_range(0, 3) != 0);
                drive(1'b0, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
                if (!b && !mSkip) begin
                    checkCycle("rnd_bpstop", IDLE_W, 1'b0, {op, 4'h0}, 2'd0, 4'd0, mSeq);
                    mHalted = 1'b1;
                end else begin
                    checkCycle("rnd_fetch", FETCH_W, 1'b0, {op, 4'h0}, 2'd0, 4'd0, mSeq);
                    mSkip = 1'b0;
                    k = progLen(op);
                    for (int st = 1; st <= k; st++) begin
                        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), op);
                        w = rom[{op, 4'(st)}];
                        checkCycle("rnd_exec", {2'b00, w[29:0]}, 1'b0, {op, 4'(st)}, 2'd1, 4'(st), mSeq);
                    end
                    w = rom[{op, 4'(k)}];
                    if (!w[31]) mSeq = 1'b1;
                    if (w[30] || mPending) begin
                        mHalted  = 1'b1;
                        mPending = 1'b0;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcode sequencer that sits directly upstream of the memory stage. It consumes the latched instruction opcode and steps a 4-bit micro-step counter through an external asynchronous microcode ROM. It produces the 32-bit control word whose low bits drive the memory stage's PC/SP/MAR/RAM/instruction-register controls. It also owns fetch, halt, breakpoint-stop and single-step sequencing, and drives the memory stage's halt input.

Parameters:
STEP_W, 4, micro-step counter width; a microprogram has at most 2^STEP_W-1 execute steps.
CTRL_W, 32, control word width.

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_instrCode  input  8  opcode latched by the memory stage
o_uRomAddress  output  12  microcode ROM address = {i_instrCode, r_step}
i_uRomData  input  32  microcode ROM data, combinational read
o_ctrlWord  output  32  control word to datapath; memory-stage fields per package bit map
o_halt  output  1  high while in HALTED; wired to memory i_halt
i_breakpointHitN  input  1  active-low breakpoint hit from memory stage
i_continue  input  1  one-cycle resume pulse
i_step  input  1  one-cycle single-instruction pulse
o_step  output  4  current micro-step (debug)
o_state  output  2  current FSM state (debug)
o_seqError  output  1  sticky: microprogram ran off step 15 without END

Behaviour:
- Reset, sampled at the clock edge:
  - Sets state=FETCH, r_step=0, r_bpSkip=0, r_stepPending=0, o_seqError=0.
  - While i_reset is high, o_ctrlWord is forced to CTRL_IDLE and o_halt=0.
- FSM states: FETCH=0, EXEC=1, HALTED=2. Encoding 3 is illegal and recovers to FETCH on the next edge.
- FETCH, r_step=0:
  - If i_breakpointHitN=0 and r_bpSkip=0: o_ctrlWord=CTRL_IDLE; next state HALTED. The fetch is not performed and the PC is unchanged.
  - Otherwise: o_ctrlWord=CTRL_FETCH (InstrNWE=0, PCNEn=0). Next state EXEC, r_step=1, r_bpSkip=0.
- EXEC, r_step=n:
  - o_ctrlWord = i_uRomData with bits 31:30 masked to 0.
  - Bit 31 (END) = 1 or n=15: instruction boundary. r_step becomes 0. n=15 without END also sets o_seqError.
    - Next state HALTED if bit 30 (HALT)=1 or r_stepPending=1; r_stepPending clears in that case.
    - Otherwise next state FETCH.
  - Otherwise: r_step <= n+1.
- HALTED:
  - o_ctrlWord=CTRL_IDLE, o_halt=1, r_step=0.
  - i_step=1: next FETCH, r_bpSkip=1, r_stepPending=1.
  - Otherwise i_continue=1: next FETCH, r_bpSkip=1. i_step wins if both pulse in the same cycle.
  - Pulses on i_step/i_continue outside HALTED are ignored.
- Latency:
  - Every non-halted cycle emits exactly one control word.
  - An instruction with k execute steps occupies k+1 cycles, fetch included.
- Outputs o_ctrlWord and o_halt are combinational from registered state and i_uRomData. No output is a registered copy of the ROM data.
- o_uRomAddress is always {i_instrCode, r_step}, including during FETCH and HALTED.

Decomposition:
- Package edic_ctrl_pkg:
  - Bit indices CTRL_PC_LOAD_N=0, PC_N_EN=1, PC_FROM_IMM=2, MEM_PC_TO_RAM_N=3, SP_UP=4, SP_N_EN=5, INSTR_N_WE=6, INSTR_N_OE=7, RAM_N_OE=8, RAM_N_WE=9, MAR0_N_WE=10, MAR1_N_WE=11, INSTR_IMM_TO_RAM_ADDR=12, bits 13-29 for ALU/register file, HALT=30, END=31.
  - CTRL_IDLE=32'h0000_0FEB.
  - CTRL_FETCH=32'h0000_0FA9.
  - State encodings.
- No sub-module; the step counter and FSM live in one block.

Test Plan:
- Reset, then opcode 8'h10 whose ROM has step1=32'h0000_0EEB and step2=32'h8000_0FEB -> ctrl words per cycle FETCH 0FA9, 0EEB, 0000_0FEB, then FETCH; addresses 12'h100, 12'h101, 12'h102.
- Step-2 word has HALT|END (32'hC000_0FEB) -> next cycle o_halt=1, ctrl=0FEB, held; i_continue pulse -> FETCH ctrl 0FA9 the following cycle.
- i_breakpointHitN=0 during FETCH -> HALTED, no InstrNWE asserted; i_continue with breakpoint still low -> fetch proceeds once (bpSkip); at the next FETCH with hit low, halts again.
- In HALTED, pulse i_step and i_continue together -> exactly one instruction executes, then HALTED again.
- Microprogram with END never set -> r_step reaches 15, returns to FETCH, o_seqError=1 stays set until i_reset.
- Assert i_reset during EXEC step 3 -> ctrl=0FEB while reset is high; first cycle after reset: state FETCH, step 0, ctrl 0FA9.
